// File: rtl/leaf_skid_stage.sv
// Two-entry skid buffer on a valid/ready stream, with a count of delivered beats
// and a running modular checksum of delivered payloads.
module leaf_skid_stage #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic [DATA_W-1:0] csum
);

  // Enumerator value equals the number of beats held.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [DATA_W-1:0] csum_q, csum_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_hs, out_hs;

  assign in_ready  = (state_q != StTwo) && !rst;
  assign out_valid = (state_q != StEmpty);
  assign out_data  = main_q;
  assign xfer_cnt  = cnt_q;
  assign csum      = csum_q;

  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;

    if (out_hs) begin
      cnt_d  = cnt_q + CNT_W'(1);
      csum_d = csum_q + main_q;
    end

    case (state_q)
      StEmpty: begin
        if (in_hs) begin
          main_d  = in_data;
          state_d = StOne;
        end
      end
      StOne: begin
        if (in_hs && out_hs) begin
          main_d = in_data;
        end else if (in_hs) begin
          skid_d  = in_data;
          state_d = StTwo;
        end else if (out_hs) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        // in_ready is low here, so only the drain path exists.
        if (out_hs) begin
          main_d  = skid_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
    end
  end

endmodule
